// File: rtl/wb_arbiter_2m4s.sv
// ============================================================================
// Module   : wb_arbiter_2m4s
// Purpose  : Wishbone B3 classic 2-master / 4-slave shared-bus arbiter and
//            decoder with round-robin grant, unmapped-access termination and
//            a stall watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter_2m4s #(
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [3:0]  S0_BASE      = 4'h0,
    parameter logic [3:0]  S1_BASE      = 4'h1,
    parameter logic [3:0]  S2_BASE      = 4'h2,
    parameter logic [3:0]  S3_BASE      = 4'h3,
    parameter logic [31:0] DEFAULT_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,

    output logic [31:0] s0_addr_o,
    output logic [31:0] s0_data_o,
    output logic [3:0]  s0_sel_o,
    output logic        s0_we_o,
    output logic        s0_cyc_o,
    output logic        s0_stb_o,
    input  logic [31:0] s0_data_i,
    input  logic        s0_ack_i,

    output logic [31:0] s1_addr_o,
    output logic [31:0] s1_data_o,
    output logic [3:0]  s1_sel_o,
    output logic        s1_we_o,
    output logic        s1_cyc_o,
    output logic        s1_stb_o,
    input  logic [31:0] s1_data_i,
    input  logic        s1_ack_i,

    output logic [31:0] s2_addr_o,
    output logic [31:0] s2_data_o,
    output logic [3:0]  s2_sel_o,
    output logic        s2_we_o,
    output logic        s2_cyc_o,
    output logic        s2_stb_o,
    input  logic [31:0] s2_data_i,
    input  logic        s2_ack_i,

    output logic [31:0] s3_addr_o,
    output logic [31:0] s3_data_o,
    output logic [3:0]  s3_sel_o,
    output logic        s3_we_o,
    output logic        s3_cyc_o,
    output logic        s3_stb_o,
    input  logic [31:0] s3_data_i,
    input  logic        s3_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        M0   = 2'd1,
        M1   = 2'd2
    } owner_t;

    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

    owner_t      owner_q, owner_d;
    logic        last_owner_q, last_owner_d;   // 1 = m1 owned last
    logic [7:0]  count_q, count_d;
    logic        timeout_q, timeout_d;
    logic        unmap_ack_q, unmap_ack_d;

    logic [31:0] w_addr, w_wdata, w_rdata, w_sdata;
    logic [3:0]  w_sel, w_hit, w_s_cyc, w_s_stb;
    logic        w_we, w_cyc, w_stb, w_req, w_mapped, w_ack;
    logic        w_m0_req, w_m1_req;

    // Owner's request mux
    always_comb begin
        w_addr  = 32'd0;
        w_wdata = 32'd0;
        w_sel   = 4'd0;
        w_we    = 1'b0;
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        case (owner_q)
            M0: begin
                w_addr = m0_addr_i; w_wdata = m0_data_i; w_sel = m0_sel_i;
                w_we   = m0_we_i;   w_cyc   = m0_cyc_i;  w_stb = m0_stb_i;
            end
            M1: begin
                w_addr = m1_addr_i; w_wdata = m1_data_i; w_sel = m1_sel_i;
                w_we   = m1_we_i;   w_cyc   = m1_cyc_i;  w_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // Priority decode: a base collision resolves to the lowest slave index
    always_comb begin
        w_hit = 4'b0000;
        if      (w_addr[31:28] == S0_BASE) w_hit = 4'b0001;
        else if (w_addr[31:28] == S1_BASE) w_hit = 4'b0010;
        else if (w_addr[31:28] == S2_BASE) w_hit = 4'b0100;
        else if (w_addr[31:28] == S3_BASE) w_hit = 4'b1000;
    end

    assign w_mapped = |w_hit;
    assign w_req    = w_cyc & w_stb;
    assign w_s_cyc  = {4{w_cyc}} & w_hit;
    assign w_s_stb  = {4{w_stb & ~timeout_q}} & w_hit;

    always_comb begin
        w_sdata = 32'd0;
        case (w_hit)
            4'b0001: w_sdata = s0_data_i;
            4'b0010: w_sdata = s1_data_i;
            4'b0100: w_sdata = s2_data_i;
            4'b1000: w_sdata = s3_data_i;
            default: w_sdata = 32'd0;
        endcase
    end

    // Slave acks only count while that slave is actually strobed
    assign w_ack = (|({s3_ack_i, s2_ack_i, s1_ack_i, s0_ack_i} & w_s_stb))
                 | (w_req & (timeout_q | (~w_mapped & unmap_ack_q)));
    assign w_rdata = (timeout_q | ~w_mapped) ? DEFAULT_DATA : w_sdata;

    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        w_m0_req     = m0_cyc_i & m0_stb_i;
        w_m1_req     = m1_cyc_i & m1_stb_i;
        case (owner_q)
            IDLE: begin
                if (w_m0_req && w_m1_req) owner_d = last_owner_q ? M0 : M1;
                else if (w_m0_req)        owner_d = M0;
                else if (w_m1_req)        owner_d = M1;
            end
            M0: if (!m0_cyc_i) begin
                owner_d      = IDLE;
                last_owner_d = 1'b0;
            end
            M1: if (!m1_cyc_i) begin
                owner_d      = IDLE;
                last_owner_d = 1'b1;
            end
            default: owner_d = IDLE;
        endcase
    end

    always_comb begin
        count_d     = 8'd0;
        timeout_d   = 1'b0;
        unmap_ack_d = w_req & ~w_mapped & ~unmap_ack_q;
        if (w_req && !w_ack && !timeout_q) begin
            if (count_q == C_TO_LAST) timeout_d = 1'b1;
            else                      count_d   = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            owner_q      <= IDLE;
            last_owner_q <= 1'b1;
            count_q      <= 8'd0;
            timeout_q    <= 1'b0;
            unmap_ack_q  <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
            timeout_q    <= timeout_d;
            unmap_ack_q  <= unmap_ack_d;
        end
    end

    assign m0_ack_o  = (owner_q == M0) & w_ack;
    assign m1_ack_o  = (owner_q == M1) & w_ack;
    assign m0_data_o = (owner_q == M0) ? w_rdata : 32'd0;
    assign m1_data_o = (owner_q == M1) ? w_rdata : 32'd0;

    assign s0_addr_o = w_addr;  assign s1_addr_o = w_addr;
    assign s2_addr_o = w_addr;  assign s3_addr_o = w_addr;
    assign s0_data_o = w_wdata; assign s1_data_o = w_wdata;
    assign s2_data_o = w_wdata; assign s3_data_o = w_wdata;
    assign s0_sel_o  = w_sel;   assign s1_sel_o  = w_sel;
    assign s2_sel_o  = w_sel;   assign s3_sel_o  = w_sel;
    assign s0_we_o   = w_we;    assign s1_we_o   = w_we;
    assign s2_we_o   = w_we;    assign s3_we_o   = w_we;

    assign {s3_cyc_o, s2_cyc_o, s1_cyc_o, s0_cyc_o} = w_s_cyc;
    assign {s3_stb_o, s2_stb_o, s1_stb_o, s0_stb_o} = w_s_stb;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m4s.sv
// ============================================================================
// Module   : tb_wb_arbiter_2m4s
// Purpose  : Directed self-checking bench for wb_arbiter_2m4s (TIMEOUT = 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter_2m4s;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] m0_addr_i = '0, m0_data_i = '0, m1_addr_i = '0, m1_data_i = '0;
    logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
    logic        m0_we_i = 1'b0, m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
    logic        m1_we_i = 1'b0, m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
    logic [31:0] m0_data_o, m1_data_o;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] s0_addr_o, s1_addr_o, s2_addr_o, s3_addr_o;
    logic [31:0] s0_data_o, s1_data_o, s2_data_o, s3_data_o;
    logic [3:0]  s0_sel_o, s1_sel_o, s2_sel_o, s3_sel_o;
    logic        s0_we_o, s1_we_o, s2_we_o, s3_we_o;
    logic        s0_cyc_o, s1_cyc_o, s2_cyc_o, s3_cyc_o;
    logic        s0_stb_o, s1_stb_o, s2_stb_o, s3_stb_o;
    logic [31:0] s0_data_i = '0, s1_data_i = '0, s2_data_i = '0, s3_data_i = '0;
    logic        s0_ack_i = 1'b0, s1_ack_i = 1'b0, s2_ack_i = 1'b0, s3_ack_i = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    wire [3:0] s_stb = {s3_stb_o, s2_stb_o, s1_stb_o, s0_stb_o};
    wire [3:0] s_cyc = {s3_cyc_o, s2_cyc_o, s1_cyc_o, s0_cyc_o};

    wb_arbiter_2m4s #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s0_addr_o(s0_addr_o), .s0_data_o(s0_data_o), .s0_sel_o(s0_sel_o),
        .s0_we_o(s0_we_o), .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o),
        .s0_data_i(s0_data_i), .s0_ack_i(s0_ack_i),
        .s1_addr_o(s1_addr_o), .s1_data_o(s1_data_o), .s1_sel_o(s1_sel_o),
        .s1_we_o(s1_we_o), .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o),
        .s1_data_i(s1_data_i), .s1_ack_i(s1_ack_i),
        .s2_addr_o(s2_addr_o), .s2_data_o(s2_data_o), .s2_sel_o(s2_sel_o),
        .s2_we_o(s2_we_o), .s2_cyc_o(s2_cyc_o), .s2_stb_o(s2_stb_o),
        .s2_data_i(s2_data_i), .s2_ack_i(s2_ack_i),
        .s3_addr_o(s3_addr_o), .s3_data_o(s3_data_o), .s3_sel_o(s3_sel_o),
        .s3_we_o(s3_we_o), .s3_cyc_o(s3_cyc_o), .s3_stb_o(s3_stb_o),
        .s3_data_i(s3_data_i), .s3_ack_i(s3_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drv_m0(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel);
        m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
        m0_addr_i = addr; m0_data_i = data; m0_sel_i = sel;
    endtask

    task automatic drv_m1(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel);
        m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
        m1_addr_i = addr; m1_data_i = data; m1_sel_i = sel;
    endtask

    initial begin
        // ---------------- reset ----------------
        step(); step();
        rst_n = 1'b0;
        s1_ack_i = 1'b1; s1_data_i = 32'h5555_AAAA;
        settle();
        chk("rst s_stb", s_stb, 32'h0);
        chk("rst s_cyc", s_cyc, 32'h0);
        chk("rst m0_ack (stray slave ack)", m0_ack_o, 32'h0);
        chk("rst m1_ack (stray slave ack)", m1_ack_o, 32'h0);
        chk("rst m0_data", m0_data_o, 32'h0);
        chk("rst m1_data", m1_data_o, 32'h0);
        s1_ack_i = 1'b0; s1_data_i = 32'h0;

        // ---------------- m1 single read from s0 ----------------
        step();
        drv_m1(1, 1, 0, 32'h0000_0010, 32'h0, 4'hF);
        settle();
        chk("t1 no stb while idle", s_stb, 32'h0);
        step(); settle();
        chk("t1 s0 stb", s_stb, 32'h1);
        chk("t1 s0 cyc", s_cyc, 32'h1);
        chk("t1 s0 addr", s0_addr_o, 32'h0000_0010);
        chk("t1 m1_ack wait1", m1_ack_o, 32'h0);
        step(); settle();
        chk("t1 m1_ack wait2", m1_ack_o, 32'h0);
        step();
        s0_ack_i = 1'b1; s0_data_i = 32'h1234_5678;
        settle();
        chk("t1 m1_ack", m1_ack_o, 32'h1);
        chk("t1 m1_data", m1_data_o, 32'h1234_5678);
        chk("t1 m0_ack", m0_ack_o, 32'h0);
        chk("t1 m0_data", m0_data_o, 32'h0);
        chk("t1 only s0 stb", s_stb, 32'h1);
        step();
        s0_ack_i = 1'b0; s0_data_i = 32'h0;
        drv_m1(0, 0, 0, 32'h0, 32'h0, 4'h0);
        settle();
        chk("t1 stb drops with cyc", s_stb, 32'h0);
        step();

        // ---------------- round-robin over 4 collisions ----------------
        step();
        drv_m0(1, 1, 0, 32'h1000_0000, 32'h0, 4'hF);
        drv_m1(1, 1, 0, 32'h2000_0000, 32'h0, 4'hF);
        settle();
        step(); settle();
        chk("t2 c1 m0 wins", s_stb, 32'h2);
        step();
        drv_m0(0, 0, 0, 32'h1000_0000, 32'h0, 4'hF);
        settle();
        chk("t2 m0 release", s_stb, 32'h0);
        step();
        drv_m0(1, 1, 0, 32'h1000_0000, 32'h0, 4'hF);
        settle();
        chk("t2 idle gap", s_stb, 32'h0);
        step(); settle();
        chk("t2 c2 m1 wins", s_stb, 32'h4);
        chk("t2 m0 not acked", m0_ack_o, 32'h0);
        step();
        drv_m1(0, 0, 0, 32'h2000_0000, 32'h0, 4'hF);
        settle();
        step();
        drv_m1(1, 1, 0, 32'h2000_0000, 32'h0, 4'hF);
        settle();
        chk("t2 idle gap 2", s_stb, 32'h0);
        step(); settle();
        chk("t2 c3 m0 wins", s_stb, 32'h2);
        step();
        drv_m0(0, 0, 0, 32'h1000_0000, 32'h0, 4'hF);
        settle();
        step();
        drv_m0(1, 1, 0, 32'h1000_0000, 32'h0, 4'hF);
        settle();
        step(); settle();
        chk("t2 c4 m1 wins", s_stb, 32'h4);
        step();
        drv_m0(0, 0, 0, 32'h0, 32'h0, 4'h0);
        drv_m1(0, 0, 0, 32'h0, 32'h0, 4'h0);
        step(); step();

        // ---------------- m0 burst of 3 writes to s2, m1 waiting ----------------
        drv_m0(1, 1, 1, 32'h2000_0000, 32'hA5A5_0001, 4'b0011);
        drv_m1(1, 1, 0, 32'h0000_0000, 32'h0, 4'hF);
        settle();
        step();
        s2_ack_i = 1'b1;
        settle();
        chk("t3 w1 stb", s_stb, 32'h4);
        chk("t3 w1 we", s2_we_o, 32'h1);
        chk("t3 w1 sel", s2_sel_o, 32'h3);
        chk("t3 w1 data", s2_data_o, 32'hA5A5_0001);
        chk("t3 w1 ack", m0_ack_o, 32'h1);
        chk("t3 w1 m1 ack", m1_ack_o, 32'h0);
        step();
        m0_data_i = 32'hA5A5_0002; m0_sel_i = 4'b1100;
        settle();
        chk("t3 w2 stb", s_stb, 32'h4);
        chk("t3 w2 sel", s2_sel_o, 32'hC);
        chk("t3 w2 data", s2_data_o, 32'hA5A5_0002);
        chk("t3 w2 ack", m0_ack_o, 32'h1);
        step();
        m0_data_i = 32'hA5A5_0003; m0_sel_i = 4'b1111;
        settle();
        chk("t3 w3 stb", s_stb, 32'h4);
        chk("t3 w3 data", s2_data_o, 32'hA5A5_0003);
        step();
        s2_ack_i = 1'b0;
        m0_stb_i = 1'b0;
        settle();
        chk("t3 m0 holds cyc, no strobes", s_stb, 32'h0);
        chk("t3 s2 cyc still held", s_cyc, 32'h4);
        step();
        m0_cyc_i = 1'b0;
        settle();
        chk("t3 m1 still waiting", s_stb, 32'h0);
        step(); settle();
        chk("t3 idle gap", s_stb, 32'h0);
        step(); settle();
        chk("t3 m1 granted", s_stb, 32'h1);
        step();
        drv_m1(0, 0, 0, 32'h0, 32'h0, 4'h0);
        drv_m0(0, 0, 0, 32'h0, 32'h0, 4'h0);
        step();

        // ---------------- unmapped m0 read ----------------
        s0_data_i = 32'hDEAD_BEEF;
        drv_m0(1, 1, 0, 32'h7000_0004, 32'h0, 4'hF);
        settle();
        step(); settle();
        chk("t4 no slave stb", s_stb, 32'h0);
        chk("t4 ack not yet", m0_ack_o, 32'h0);
        step(); settle();
        chk("t4 internal ack", m0_ack_o, 32'h1);
        chk("t4 default data", m0_data_o, 32'h0);
        step(); settle();
        chk("t4 ack one cycle", m0_ack_o, 32'h0);
        step();
        drv_m0(0, 0, 0, 32'h0, 32'h0, 4'h0);
        s0_data_i = 32'h0;
        step();

        // ---------------- watchdog on s3 ----------------
        s3_data_i = 32'hCAFE_F00D;
        drv_m1(1, 1, 0, 32'h3000_0000, 32'h0, 4'hF);
        settle();
        for (int i = 1; i <= 8; i++) begin
            step(); settle();
            chk($sformatf("t5 strobe cycle %0d stb", i), s_stb, 32'h8);
            chk($sformatf("t5 strobe cycle %0d ack", i), m1_ack_o, 32'h0);
        end
        step();
        s3_ack_i = 1'b1;
        settle();
        chk("t5 forced ack", m1_ack_o, 32'h1);
        chk("t5 forced data", m1_data_o, 32'h0);
        chk("t5 s3 stb low", s_stb, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            step();
            s3_ack_i = 1'b0;
            settle();
            chk($sformatf("t5 restart cycle %0d ack", i), m1_ack_o, 32'h0);
        end
        step(); settle();
        chk("t5 second forced ack", m1_ack_o, 32'h1);
        step();
        drv_m1(0, 0, 0, 32'h0, 32'h0, 4'h0);
        s3_data_i = 32'h0;
        step();

        // ---------------- reset mid-cycle ----------------
        drv_m0(1, 1, 0, 32'h1000_0000, 32'h0, 4'hF);
        settle();
        step(); settle();
        chk("t6 m0 on s1", s_stb, 32'h2);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        settle();
        step(); settle();
        chk("t6 m0 on s1 again", s_stb, 32'h2);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        s1_ack_i = 1'b1;
        drv_m1(1, 1, 0, 32'h2000_0000, 32'h0, 4'hF);
        settle();
        chk("t6 post-reset stb", s_stb, 32'h0);
        chk("t6 post-reset cyc", s_cyc, 32'h0);
        chk("t6 post-reset m0_ack", m0_ack_o, 32'h0);
        chk("t6 post-reset m1_ack", m1_ack_o, 32'h0);
        chk("t6 post-reset m0_data", m0_data_o, 32'h0);
        step();
        s1_ack_i = 1'b0;
        settle();
        chk("t6 collision after reset m0 wins", s_stb, 32'h2);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step(); settle();
        chk("t6 idle gap", s_stb, 32'h0);
        step(); settle();
        chk("t6 m1 granted", s_stb, 32'h4);
        step();
        drv_m1(0, 0, 0, 32'h0, 32'h0, 4'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
